alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle combinational datapath ALU.
- Same control encodings as the existing ALU: AND, OR, ADD, SUB, PassB.
- Adds logical shifts, an iterative shift-add multiply, full NZCV flags and a Start/Busy/Done handshake.
- Sits between the register-file read ports and the writeback mux of the multi-cycle datapath; the controller issues one operation at a time.

---
 rtl/alu_seq.sv | 126 ++++++++++++
 tb/tb_alu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arith/shift ops and an iterative shift-add multiply.
// States: IDLE | idle, accepts Start ; MUL | shift-add iterations, Busy high
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        sum_add = {1'b0, BusA} + {1'b0, BusB};
        sum_sub = {1'b0, BusA} + {1'b0, ~BusB} + (WIDTH+1)'(1);
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (ALUCtrl)
            4'd0: res = BusA & BusB;
            4'd1: res = BusA | BusB;
            4'd2: begin
                res   = sum_add[WIDTH-1:0];
                res_c = sum_add[WIDTH];
                res_v = (BusA[WIDTH-1] == BusB[WIDTH-1]) &&
                        (sum_add[WIDTH-1] != BusA[WIDTH-1]);
            end
            4'd3: res = BusA << BusB[SHW-1:0];
            4'd4: res = BusA >> BusB[SHW-1:0];
            4'd6: begin
                // carry set means no borrow
                res   = sum_sub[WIDTH-1:0];
                res_c = sum_sub[WIDTH];
                res_v = (BusA[WIDTH-1] != BusB[WIDTH-1]) &&
                        (sum_sub[WIDTH-1] != BusA[WIDTH-1]);
            end
            4'd7: res = BusB;
            default: res = '0;
        endcase
    end

    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            BusW     <= '0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (ALUCtrl == 4'd8) begin
                            state  <= MUL;
                            Busy   <= 1'b1;
                            mcand  <= BusA;
                            mplier <= BusB;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            Done     <= 1'b1;
                            BusW     <= res;
                            Zero     <= (res == '0);
                            Negative <= res[WIDTH-1];
                            Carry    <= res_c;
                            Overflow <= res_v;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH-1)) begin
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        BusW     <= acc_next;
                        Zero     <= (acc_next == '0);
                        Negative <= acc_next[WIDTH-1];
                        Carry    <= 1'b0;
                        Overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor checks each Done.
module tb_alu_seq;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  ALUCtrl = 4'd0;
    logic [63:0] BusA = '0;
    logic [63:0] BusB = '0;
    logic        Busy, Done, Zero, Negative, Carry, Overflow;
    logic [63:0] BusW;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] w;
        logic [3:0]  f;   // {Z,N,C,V}
    } exp_t;
    exp_t q[$];

    alu_seq #(.WIDTH(64)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
        .BusA(BusA), .BusB(BusB), .Busy(Busy), .Done(Done), .BusW(BusW),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Done=1 expected no result pending (BusW=%h)", BusW);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("busw", BusW, e.w);
                chk("flags_zncv", {60'd0, Zero, Negative, Carry, Overflow}, {60'd0, e.f});
                chk("busy_at_done", {63'd0, Busy}, 64'd0);
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] w, input logic [3:0] f);
        Start = 1'b1;
        ALUCtrl = c;
        BusA = a;
        BusB = b;
        q.push_back('{w: w, f: f});
        @(negedge Clk);
    endtask

    task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] w, input logic [3:0] f);
        drive(c, a, b, w, f);
        Start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busw"}, BusW, 64'd0);
        chk({tag, "_ctl_flags"}, {58'd0, Busy, Done, Zero, Negative, Carry, Overflow}, 64'd0);
    endtask

    initial begin
        int done_k;
        int busy_cnt;

        repeat (2) @(negedge Clk);
        check_reset_state("reset_init");
        Reset = 1'b0;
        @(negedge Clk);

        // Produce nonzero outputs, then reset mid-run for 2 cycles
        issue(4'd7, 64'd0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b0100);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_reset_state("reset_mid");
        Reset = 1'b0;
        @(negedge Clk);

        issue(4'd0, 64'h21389, 64'h12398, 64'h388, 4'b0000);
        issue(4'd6, 64'h9231, 64'h8128789, 64'hFFFF_FFFF_F7EE_0AA8, 4'b0100);
        issue(4'd6, 64'hFFFA, 64'hFFFA, 64'd0, 4'b1010);
        issue(4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101);
        issue(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010);
        issue(4'd1, 64'hF0, 64'h0F, 64'hFF, 4'b0000);

        // MUL with timing checks, ignored Start and operand change mid-run
        Start = 1'b1; ALUCtrl = 4'd8; BusA = 64'h1234; BusB = 64'h10;
        q.push_back('{w: 64'h12340, f: 4'b0000});
        done_k = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                done_k = k;
                break;
            end
            if (Busy === 1'b1) busy_cnt++;
            if (k == 1) Start = 1'b0;
            if (k == 5) BusA = 64'hFFFF;
            if (k == 10) begin
                Start = 1'b1; ALUCtrl = 4'd1; BusA = 64'h5; BusB = 64'hA;
            end
            if (k == 11) Start = 1'b0;
            if (k == 20) chk("mul_busw_held", BusW, 64'hFF);
        end
        chk("mul_done_latency", 64'(done_k), 64'd65);
        chk("mul_busy_cycles", 64'(busy_cnt), 64'd64);
        @(negedge Clk);

        // MUL aborted by Reset at iteration 20: no expected result pushed
        Start = 1'b1; ALUCtrl = 4'd8; BusA = 64'h3; BusB = 64'h5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) Start = 1'b0;
        end
        Reset = 1'b1;
        @(negedge Clk);
        check_reset_state("mul_abort");
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("mul_abort_busy", {63'd0, Busy}, 64'd0);

        issue(4'd7, 64'd0, 64'h8799BC, 64'h8799BC, 4'b0000);

        // Back-to-back: LSL then LSR started on the LSL Done cycle
        drive(4'd3, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b0100);
        drive(4'd4, 64'h8, 64'h41, 64'h4, 4'b0000);
        Start = 1'b0;
        @(negedge Clk);
        issue(4'd15, 64'hFFFF, 64'hFFFF, 64'd0, 4'b1000);
        issue(4'd5, 64'h1, 64'h1, 64'd0, 4'b1000);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge Clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results still pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
